// File: rtl/sync_fifo_param_pkg.sv
// sync_fifo_pkg: shared pointer type, sizing helpers and parameter legality check for sync_fifo_param
// Pointers use one fixed-width struct; only the low $clog2(DEPTH) address bits are live.
package sync_fifo_pkg;
  localparam int MAX_AW = 16;
  localparam int PW = MAX_AW + 1;
  typedef struct packed {
    logic              phase;
    logic [MAX_AW-1:0] addr;
  } ptr_t;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  // Linear position with the phase bit sitting just above the live address bits.
  function automatic logic [PW-1:0] ptr_lin(input ptr_t p, input int aw);
    return (PW'(p.phase) << aw) | PW'(p.addr);
  endfunction
  function automatic bit cfg_ok(input int depth, input int af, input int ae);
    return depth >= 2 && (depth & (depth - 1)) == 0 && depth <= 2 ** MAX_AW &&
           af >= 1 && af <= depth && ae >= 0 && ae < depth;
  endfunction
endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: producer/consumer handshake bundle of the parametrised FIFO
// master = the block driving requests; slave = the FIFO itself.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic              write_en;
  logic [DATA_W-1:0] write_data;
  logic              full;
  logic              almost_full;
  logic              read_en;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;
  logic              empty;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;
  logic              err_clear;
  modport master (
    output write_en, write_data, read_en, err_clear,
    input  full, almost_full, read_data, read_valid, empty, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  write_en, write_data, read_en, err_clear,
    output full, almost_full, read_data, read_valid, empty, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param_ptr.sv
// fifo_ptr: phase-bit FIFO pointer, advances on inc and toggles phase when wrapping from DEPTH-1 to 0
// Ports: clk, reset_n (async, active-low), inc (advance), ptr (phase + address).
module fifo_ptr
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  output ptr_t ptr
);
  logic wrap;
  assign wrap = ptr.addr == MAX_AW'(DEPTH - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ptr <= '0;
    else if (inc) ptr <= {ptr.phase ^ wrap, wrap ? {MAX_AW{1'b0}} : ptr.addr + MAX_AW'(1)};
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with count, almost flags, show-ahead/registered read, sticky errors
// Ports: clk, reset_n (async, active-low), bus (sync_fifo_param_if.slave: write/read handshakes, flags, count, errors).
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int SHOW_AHEAD = 1
) (
  input logic              clk,
  input logic              reset_n,
  sync_fifo_param_if.slave bus
);
  localparam int AW = ptr_w(DEPTH);
  localparam int CW = AW + 1;
  if (!cfg_ok(DEPTH, AF_LEVEL, AE_LEVEL) || DATA_W < 1) begin : g_bad_cfg
    $fatal(1, "sync_fifo_param: illegal DATA_W/DEPTH/AF_LEVEL/AE_LEVEL");
  end
  ptr_t              wp, rp;
  logic              wr_ok, rd_ok, full, empty, ovf, udf;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] mem [DEPTH];
  // Flags come only from registered pointers, so requests never reach them combinationally.
  assign full  = wp.addr == rp.addr && wp.phase != rp.phase;
  assign empty = wp.addr == rp.addr && wp.phase == rp.phase;
  assign count = CW'(ptr_lin(wp, AW) - ptr_lin(rp, AW));
  assign wr_ok = bus.write_en && !full;
  assign rd_ok = bus.read_en && !empty;
  fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (.clk(clk), .reset_n(reset_n), .inc(wr_ok), .ptr(wp));
  fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (.clk(clk), .reset_n(reset_n), .inc(rd_ok), .ptr(rp));
  always_ff @(posedge clk)
    if (wr_ok) mem[wp.addr[AW-1:0]] <= bus.write_data;
  // A new error in the same cycle as err_clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= (bus.write_en && full) || (ovf && !bus.err_clear);
      udf <= (bus.read_en && empty) || (udf && !bus.err_clear);
    end
  if (SHOW_AHEAD != 0) begin : g_show_ahead
    assign bus.read_data  = mem[rp.addr[AW-1:0]];
    assign bus.read_valid = 1'b0;
  end else begin : g_registered
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        rdata  <= '0;
        rvalid <= 1'b0;
      end else begin
        rvalid <= rd_ok;
        if (rd_ok) rdata <= mem[rp.addr[AW-1:0]];
      end
    assign bus.read_data  = rdata;
    assign bus.read_valid = rvalid;
  end
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = count;
  assign bus.almost_full  = count >= CW'(AF_LEVEL);
  assign bus.almost_empty = count <= CW'(AE_LEVEL);
  assign bus.overflow     = ovf;
  assign bus.underflow    = udf;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: scoreboard bench driving a show-ahead and a registered-read FIFO with identical stimulus
module tb_sync_fifo_param;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       we = 1'b0, re = 1'b0, ec = 1'b0;
  logic [7:0] wd = 8'h00;
  int         n_chk = 0, n_fail = 0;
  logic [7:0] q[$];
  bit         m_ovf = 1'b0, m_udf = 1'b0;
  logic [9:0] st_a, st_b;
  localparam logic [9:0] RST_ST = 10'b0011_00_0000;
  always #5 clk = ~clk;
  sync_fifo_param_if #(.DATA_W(8), .DEPTH(8)) ia ();
  sync_fifo_param_if #(.DATA_W(8), .DEPTH(8)) ib ();
  assign ia.write_en = we;
  assign ia.write_data = wd;
  assign ia.read_en = re;
  assign ia.err_clear = ec;
  assign ib.write_en = we;
  assign ib.write_data = wd;
  assign ib.read_en = re;
  assign ib.err_clear = ec;
  sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .SHOW_AHEAD(1))
    u_sa (.clk(clk), .reset_n(reset_n), .bus(ia));
  sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .SHOW_AHEAD(0))
    u_reg (.clk(clk), .reset_n(reset_n), .bus(ib));
  assign st_a = {ia.full, ia.almost_full, ia.empty, ia.almost_empty, ia.overflow, ia.underflow, ia.count};
  assign st_b = {ib.full, ib.almost_full, ib.empty, ib.almost_empty, ib.overflow, ib.underflow, ib.count};
  function automatic logic [9:0] exp_st();
    int n;
    n = q.size();
    return {n == 8, n >= 6, n == 0, n <= 2, m_ovf, m_udf, 4'(n)};
  endfunction
  // One clock of stimulus from a falling edge: samples the show-ahead head before the edge,
  // updates the scoreboard and returns at the next falling edge.
  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c,
                      output bit racc, output logic [7:0] head, output logic [7:0] sa_seen);
    bit wacc;
    we = w; wd = d; re = r; ec = c;
    #1 sa_seen = ia.read_data;
    racc = r && q.size() > 0;
    wacc = w && q.size() < 8;
    m_ovf = (w && q.size() == 8) || (m_ovf && !c);
    m_udf = (r && q.size() == 0) || (m_udf && !c);
    head = racc ? q.pop_front() : 8'h00;
    if (wacc) q.push_back(d);
    @(posedge clk);
    @(negedge clk);
    we = 1'b0; re = 1'b0; ec = 1'b0;
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_chk++; if (st_a !== RST_ST) begin n_fail++; $display("FAIL reset status_sa: got %b want %b", st_a, RST_ST); end
    n_chk++; if (st_b !== RST_ST) begin n_fail++; $display("FAIL reset status_reg: got %b want %b", st_b, RST_ST); end
    n_chk++; if (ib.read_valid !== 1'b0) begin n_fail++; $display("FAIL reset read_valid: got %b want 0", ib.read_valid); end
    n_chk++; if (ib.read_data !== 8'h00) begin n_fail++; $display("FAIL reset read_data: got %h want 00", ib.read_data); end
    n_chk++; if (ia.read_valid !== 1'b0) begin n_fail++; $display("FAIL reset sa read_valid: got %b want 0", ia.read_valid); end
  endtask
  task automatic test_fill_overflow();
    bit ra; logic [7:0] hd, sa;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 8'(i + 1), 1'b0, 1'b0, ra, hd, sa);
      n_chk++; if (st_a !== exp_st()) begin n_fail++; $display("FAIL fill status i=%0d: got %b want %b", i, st_a, exp_st()); end
      n_chk++; if (ia.full !== (i >= 7)) begin n_fail++; $display("FAIL fill full i=%0d: got %b", i, ia.full); end
    end
    n_chk++; if (ia.overflow !== 1'b1 || ia.count !== 4'd8) begin n_fail++; $display("FAIL overflow: ovf %b count %0d want 1 8", ia.overflow, ia.count); end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, ra, hd, sa);
      n_chk++; if (sa !== 8'(i + 1)) begin n_fail++; $display("FAIL drain sa_data i=%0d: got %h want %h", i, sa, 8'(i + 1)); end
      n_chk++; if (ib.read_valid !== 1'b1 || ib.read_data !== 8'(i + 1)) begin n_fail++; $display("FAIL drain reg_data i=%0d: got %b/%h want 1/%h", i, ib.read_valid, ib.read_data, 8'(i + 1)); end
      n_chk++; if (st_b !== exp_st()) begin n_fail++; $display("FAIL drain status i=%0d: got %b want %b", i, st_b, exp_st()); end
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, ra, hd, sa);
    n_chk++; if (ib.read_valid !== 1'b0 || ia.empty !== 1'b1) begin n_fail++; $display("FAIL drain end: valid %b empty %b want 0 1", ib.read_valid, ia.empty); end
  endtask
  task automatic test_wrap();
    bit ra; logic [7:0] hd, sa;
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, ra, hd, sa);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, ra, hd, sa);
      n_chk++; if (sa !== hd || ib.read_data !== hd) begin n_fail++; $display("FAIL wrap pre i=%0d: got %h/%h want %h", i, sa, ib.read_data, hd); end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, ra, hd, sa);
      n_chk++; if (ia.count !== 4'(i + 1)) begin n_fail++; $display("FAIL wrap count up i=%0d: got %0d want %0d", i, ia.count, i + 1); end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, ra, hd, sa);
      n_chk++; if (sa !== 8'(8'hA0 + i) || ib.read_data !== 8'(8'hA0 + i)) begin n_fail++; $display("FAIL wrap order i=%0d: got %h/%h want %h", i, sa, ib.read_data, 8'(8'hA0 + i)); end
      n_chk++; if (ia.count !== 4'(7 - i)) begin n_fail++; $display("FAIL wrap count down i=%0d: got %0d want %0d", i, ia.count, 7 - i); end
    end
  endtask
  task automatic test_simultaneous();
    bit ra; logic [7:0] hd, sa;
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, ra, hd, sa);
    step(1'b1, 8'h55, 1'b1, 1'b0, ra, hd, sa);
    n_chk++; if (sa !== 8'h30 || ib.read_valid !== 1'b1) begin n_fail++; $display("FAIL full both read: got %h/%b want 30/1", sa, ib.read_valid); end
    n_chk++; if (ia.count !== 4'd7 || ia.overflow !== 1'b1) begin n_fail++; $display("FAIL full both: count %0d ovf %b want 7 1", ia.count, ia.overflow); end
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, ra, hd, sa);
      n_chk++; if (sa !== 8'(8'h31 + i)) begin n_fail++; $display("FAIL full both drain i=%0d: got %h want %h", i, sa, 8'(8'h31 + i)); end
    end
    step(1'b1, 8'h66, 1'b1, 1'b0, ra, hd, sa);
    n_chk++; if (ia.count !== 4'd1 || ia.underflow !== 1'b1 || ib.read_valid !== 1'b0) begin n_fail++; $display("FAIL empty both: count %0d udf %b valid %b want 1 1 0", ia.count, ia.underflow, ib.read_valid); end
    step(1'b0, 8'h00, 1'b1, 1'b0, ra, hd, sa);
    n_chk++; if (sa !== 8'h66 || ib.read_data !== 8'h66) begin n_fail++; $display("FAIL empty both data: got %h/%h want 66", sa, ib.read_data); end
    n_chk++; if (st_a !== exp_st()) begin n_fail++; $display("FAIL empty both status: got %b want %b", st_a, exp_st()); end
  endtask
  task automatic test_thresholds();
    bit ra; logic [7:0] hd, sa;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, ra, hd, sa);
      n_chk++; if (ia.almost_full !== (i + 1 >= 6) || ia.almost_empty !== (i + 1 <= 2)) begin n_fail++; $display("FAIL thresh up n=%0d: af %b ae %b", i + 1, ia.almost_full, ia.almost_empty); end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, ra, hd, sa);
      n_chk++; if (ib.almost_full !== (7 - i >= 6) || ib.almost_empty !== (7 - i <= 2)) begin n_fail++; $display("FAIL thresh down n=%0d: af %b ae %b", 7 - i, ib.almost_full, ib.almost_empty); end
      n_chk++; if (ib.read_valid !== 1'b1 || ib.read_data !== hd) begin n_fail++; $display("FAIL thresh reg read i=%0d: got %b/%h want 1/%h", i, ib.read_valid, ib.read_data, hd); end
    end
  endtask
  task automatic test_err_clear();
    bit ra; logic [7:0] hd, sa;
    n_chk++; if (ia.overflow !== 1'b1 || ia.underflow !== 1'b1) begin n_fail++; $display("FAIL err before clear: ovf %b udf %b want 1 1", ia.overflow, ia.underflow); end
    step(1'b0, 8'h00, 1'b1, 1'b1, ra, hd, sa);
    n_chk++; if (ia.overflow !== 1'b0 || ia.underflow !== 1'b1) begin n_fail++; $display("FAIL err set wins: ovf %b udf %b want 0 1", ia.overflow, ia.underflow); end
    step(1'b0, 8'h00, 1'b0, 1'b1, ra, hd, sa);
    n_chk++; if (st_b !== exp_st() || ib.underflow !== 1'b0) begin n_fail++; $display("FAIL err clear: got %b want %b", st_b, exp_st()); end
  endtask
  task automatic test_async_reset();
    bit ra; logic [7:0] hd, sa;
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, ra, hd, sa);
    step(1'b0, 8'h00, 1'b1, 1'b0, ra, hd, sa);
    n_chk++; if (ia.count !== 4'd5 || ib.read_valid !== 1'b1 || ib.read_data !== 8'h70) begin n_fail++; $display("FAIL pre-reset: count %0d valid %b data %h want 5 1 70", ia.count, ib.read_valid, ib.read_data); end
    #2 reset_n = 1'b0;
    #1;
    n_chk++; if (st_a !== RST_ST || st_b !== RST_ST) begin n_fail++; $display("FAIL async reset status: got %b/%b want %b", st_a, st_b, RST_ST); end
    n_chk++; if (ib.read_valid !== 1'b0 || ib.read_data !== 8'h00) begin n_fail++; $display("FAIL async reset read: got %b/%h want 0/00", ib.read_valid, ib.read_data); end
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 8'h99, 1'b0, 1'b0, ra, hd, sa);
    step(1'b0, 8'h00, 1'b1, 1'b0, ra, hd, sa);
    n_chk++; if (sa !== 8'h99 || ib.read_data !== 8'h99) begin n_fail++; $display("FAIL post-reset data: got %h/%h want 99", sa, ib.read_data); end
    n_chk++; if (st_a !== exp_st()) begin n_fail++; $display("FAIL post-reset status: got %b want %b", st_a, exp_st()); end
  endtask
  initial begin
    test_reset();
    test_fill_overflow();
    test_wrap();
    test_simultaneous();
    test_thresholds();
    test_err_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
